// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester add/sub/compare controller:
// function codes, compare selectors and FSM state encoding.
package alu_share_pkg;

  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_CMPEQ = 3'b011;
  localparam logic [2:0] FN_CMPLT = 3'b101;
  localparam logic [2:0] FN_CMPLE = 3'b111;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_EQ   = 2'b01,
    CMP_LT   = 2'b10,
    CMP_LE   = 2'b11
  } cmp_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Any non-arithmetic selector forces a subtraction.
  function automatic logic is_compare(input logic [2:0] fn);
    return fn[2:1] != 2'b00;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational shared datapath: carry-lookahead add/sub, Z/V/N flags and
// compare-bit selection. Carry-out of the top bit is intentionally dropped.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fn,
  output logic [WIDTH-1:0] data,
  output logic             z,
  output logic             v,
  output logic             n
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             cmp_bit;
  cmp_sel_t         cmp_sel;

  // Flat lookahead: carry out of bit `top` from generate/propagate terms.
  function automatic logic cla_carry(input logic [WIDTH-1:0] g,
                                     input logic [WIDTH-1:0] p,
                                     input logic             cin,
                                     input int               top);
    logic c;
    logic prod;
    c    = 1'b0;
    prod = 1'b1;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (j <= top) begin
        c    = c | (prod & g[j]);
        prod = prod & p[j];
      end
    end
    return c | (prod & cin);
  endfunction

  assign sub      = fn[0] | is_compare(fn);
  assign b_eff    = sub ? ~b : b;
  assign gen      = a & b_eff;
  assign prop     = a ^ b_eff;
  assign carry[0] = sub;

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi] = cla_carry(gen, prop, sub, gi - 1);
    end
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign sum[gi] = prop[gi] ^ carry[gi];
    end
  endgenerate

  assign z = (sum == '0);
  assign n = sum[WIDTH-1];
  assign v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    cmp_sel = cmp_sel_t'(fn[2:1]);
    cmp_bit = 1'b0;
    case (cmp_sel)
      CMP_EQ:  cmp_bit = z;
      CMP_LT:  cmp_bit = n ^ v;
      CMP_LE:  cmp_bit = z | (n ^ v);
      default: cmp_bit = 1'b0;
    endcase
    data = is_compare(fn) ? {{(WIDTH-1){1'b0}}, cmp_bit} : sum;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin two-requester front end for the shared ALU: IDLE grants and
// captures, EXEC registers the datapath result, RESP holds it until taken.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [2:0]       i_req0_fn,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [2:0]       i_req1_fn,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_z,
  output logic             o_rsp_v,
  output logic             o_rsp_n,
  output logic             o_busy
);

  state_t           state_reg;
  logic             ptr_reg;
  logic             id_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2:0]       fn_reg;
  logic             rsp_valid_reg;
  logic             rsp_id_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_z_reg;
  logic             rsp_v_reg;
  logic             rsp_n_reg;
  logic             busy_reg;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] core_data;
  logic             core_z;
  logic             core_v;
  logic             core_n;

  // Readies are gated by reset so every output reads 0 while it is held.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr_reg;
    if (i_rst_n && state_reg == ST_IDLE) begin
      if (i_req0_valid && i_req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ptr_reg;
      end else if (i_req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (i_req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign o_req0_ready = grant_valid & ~grant_id;
  assign o_req1_ready = grant_valid & grant_id;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_reg),
    .b    (b_reg),
    .fn   (fn_reg),
    .data (core_data),
    .z    (core_z),
    .v    (core_v),
    .n    (core_n)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= 1'b0;
      id_reg        <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      fn_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_z_reg     <= 1'b0;
      rsp_v_reg     <= 1'b0;
      rsp_n_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            a_reg     <= grant_id ? i_req1_a  : i_req0_a;
            b_reg     <= grant_id ? i_req1_b  : i_req0_b;
            fn_reg    <= grant_id ? i_req1_fn : i_req0_fn;
            id_reg    <= grant_id;
            ptr_reg   <= ~grant_id;
            busy_reg  <= 1'b1;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_reg  <= core_data;
          rsp_z_reg     <= core_z;
          rsp_v_reg     <= core_v;
          rsp_n_reg     <= core_n;
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_reg;
  assign o_rsp_id    = rsp_id_reg;
  assign o_rsp_data  = rsp_data_reg;
  assign o_rsp_z     = rsp_z_reg;
  assign o_rsp_v     = rsp_v_reg;
  assign o_rsp_n     = rsp_n_reg;
  assign o_busy      = busy_reg;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl at WIDTH=8: directed vectors,
// arbitration, backpressure, asynchronous reset and randomized operations.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_req0_valid = 1'b0;
  logic [W-1:0] i_req0_a = '0;
  logic [W-1:0] i_req0_b = '0;
  logic [2:0]   i_req0_fn = '0;
  logic         i_req1_valid = 1'b0;
  logic [W-1:0] i_req1_a = '0;
  logic [W-1:0] i_req1_b = '0;
  logic [2:0]   i_req1_fn = '0;
  logic         i_rsp_ready = 1'b0;
  logic         o_req0_ready;
  logic         o_req1_ready;
  logic         o_rsp_valid;
  logic         o_rsp_id;
  logic [W-1:0] o_rsp_data;
  logic         o_rsp_z;
  logic         o_rsp_v;
  logic         o_rsp_n;
  logic         o_busy;

  logic [W+7:0] all_outs;
  logic [W+2:0] rsp_all;
  assign all_outs = {o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id,
                     o_rsp_data, o_rsp_z, o_rsp_v, o_rsp_n, o_busy};
  assign rsp_all  = {o_rsp_data, o_rsp_z, o_rsp_v, o_rsp_n};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req0_valid (i_req0_valid),
    .o_req0_ready (o_req0_ready),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req0_fn    (i_req0_fn),
    .i_req1_valid (i_req1_valid),
    .o_req1_ready (o_req1_ready),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req1_fn    (i_req1_fn),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_z      (o_rsp_z),
    .o_rsp_v      (o_rsp_v),
    .o_rsp_n      (o_rsp_n),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Grant exclusivity and "no ready while busy" hold on every cycle.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      checks++;
      if ((o_req0_ready && o_req1_ready) || ((o_req0_ready || o_req1_ready) && o_busy)) begin
        failures++;
        $display("FAIL ready_excl: got r0=%b r1=%b busy=%b at cycle %0d", o_req0_ready, o_req1_ready, o_busy, cyc);
      end
    end
  end

  // Reference: signed integer arithmetic, result {data, z, v, n}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] fn);
    int sa, sb, r;
    logic [W-1:0] s, d;
    logic z, v, n;
    sa = $signed(a);
    sb = $signed(b);
    r  = (fn[0] || fn[2:1] != 2'b00) ? sa - sb : sa + sb;
    s  = r[W-1:0];
    z  = (s == '0);
    n  = s[W-1];
    v  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    case (fn[2:1])
      2'b00:   d = s;
      2'b01:   d = W'(sa == sb);
      2'b10:   d = W'(sa < sb);
      default: d = W'(sa <= sb);
    endcase
    return {d, z, v, n};
  endfunction

  task automatic drive(input bit id, input logic vld, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] fn);
    if (id == 1'b0) begin
      i_req0_valid = vld; i_req0_a = a; i_req0_b = b; i_req0_fn = fn;
    end else begin
      i_req1_valid = vld; i_req1_a = a; i_req1_b = b; i_req1_fn = fn;
    end
  endtask

  task automatic do_reset;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    i_rsp_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Issue one request, scramble operands after acceptance, collect response.
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] fn, input int stall,
                       output bit ok, output int lat, output logic rdy_after,
                       output logic rid, output logic [W+2:0] res);
    int acc_cyc;
    bit got;
    ok = 1'b0; lat = -1; rdy_after = 1'b0; rid = 1'b0; res = '0; acc_cyc = 0;
    @(negedge i_clk);
    i_rsp_ready = (stall == 0);
    drive(id, 1'b1, a, b, fn);
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((id ? o_req1_ready : o_req0_ready) === 1'b1) begin
        got = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge i_clk);
      #1;
    end
    if (!got) begin
      drive(id, 1'b0, a, b, fn);
    end else begin
      @(posedge i_clk);
      #1;
      rdy_after = id ? o_req1_ready : o_req0_ready;
      drive(id, 1'b0, W'($urandom), W'($urandom), 3'($urandom));
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge i_clk);
        if (o_rsp_valid === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (got) begin
        lat = cyc - acc_cyc;
        rid = o_rsp_id;
        res = rsp_all;
        for (int s = 0; s < stall; s++) @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rsp_ready = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    i_rst_n = 1'b0;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    @(negedge i_clk);
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_hold_outs: got %h expected 0", all_outs);
    end
    @(negedge i_clk);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("FAIL reset_idle_outs: got %h expected 0", all_outs);
    end
  endtask

  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   fn;
    logic [W+2:0] exp;
  } vec_t;

  task automatic test_directed;
    vec_t vecs [5];
    bit ok; int lat; logic rdy_after, rid; logic [W+2:0] res;
    vecs[0] = '{1'b0, 8'h7F, 8'h01, FN_ADD,   {8'h80, 1'b0, 1'b1, 1'b1}};
    vecs[1] = '{1'b1, 8'h05, 8'h05, FN_SUB,   {8'h00, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{1'b0, 8'hFD, 8'h02, FN_CMPLT, {8'h01, 1'b0, 1'b0, 1'b1}};
    vecs[3] = '{1'b0, 8'h02, 8'h02, FN_CMPLE, {8'h01, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{1'b1, 8'h03, 8'h02, FN_CMPEQ, {8'h00, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fn, 0, ok, lat, rdy_after, rid, res);
      $display("directed %0d: id=%0d a=%h b=%h fn=%b -> rsp=%h id=%0d lat=%0d",
               i, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fn, res, rid, lat);
      checks++;
      if (!ok) begin failures++; $display("FAIL dir_timeout[%0d]: got no response expected one", i); end
      checks++;
      if (res !== vecs[i].exp) begin failures++; $display("FAIL dir_result[%0d]: got %h expected %h", i, res, vecs[i].exp); end
      checks++;
      if (rid !== vecs[i].id) begin failures++; $display("FAIL dir_id[%0d]: got %0d expected %0d", i, rid, vecs[i].id); end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL dir_latency[%0d]: got %0d expected 2", i, lat); end
      checks++;
      if (rdy_after !== 1'b0) begin failures++; $display("FAIL dir_ready_pulse[%0d]: got %b expected 0", i, rdy_after); end
    end
  endtask

  task automatic test_back_to_back;
    bit exp_turn, eid;
    int nresp;
    bit q[$];
    logic [W+2:0] e0, e1;
    do_reset;
    e0 = model(8'h11, 8'h22, FN_ADD);
    e1 = model(8'h80, 8'h01, FN_CMPLT);
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h11, 8'h22, FN_ADD);
    drive(1'b1, 1'b1, 8'h80, 8'h01, FN_CMPLT);
    #1;
    exp_turn = 1'b0;
    nresp = 0;
    for (int k = 0; k < 40 && nresp < 4; k++) begin
      if (o_req0_ready || o_req1_ready) begin
        checks++;
        if (o_req1_ready !== exp_turn) begin
          failures++;
          $display("FAIL b2b_grant: got req%0d expected req%0d", o_req1_ready, exp_turn);
        end
        q.push_back(exp_turn);
        exp_turn = ~exp_turn;
      end
      if (o_rsp_valid) begin
        eid = (q.size() > 0) ? q.pop_front() : 1'b0;
        $display("b2b rsp %0d: id=%0d rsp=%h", nresp, o_rsp_id, rsp_all);
        checks++;
        if (o_rsp_id !== eid) begin failures++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", nresp, o_rsp_id, eid); end
        checks++;
        if (rsp_all !== (eid ? e1 : e0)) begin
          failures++;
          $display("FAIL b2b_result[%0d]: got %h expected %h", nresp, rsp_all, eid ? e1 : e0);
        end
        nresp++;
      end
      if (nresp < 4) begin
        @(negedge i_clk);
        #1;
      end
    end
    checks++;
    if (nresp != 4) begin failures++; $display("FAIL b2b_count: got %0d responses expected 4", nresp); end
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_backpressure;
    logic [W+2:0] e0, e1;
    bit got;
    do_reset;
    e0 = model(8'h10, 8'h20, FN_ADD);
    e1 = model(8'h10, 8'h30, FN_SUB);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 8'h10, 8'h20, FN_ADD);
    drive(1'b1, 1'b1, 8'h10, 8'h30, FN_SUB);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge i_clk);
      got = (o_rsp_valid === 1'b1);
    end
    checks++;
    if (!got) begin failures++; $display("FAIL bp_first_timeout: got no response expected one"); end
    checks++;
    if ({o_rsp_id, rsp_all} !== {1'b0, e0}) begin
      failures++;
      $display("FAIL bp_first: got id=%0d %h expected id=0 %h", o_rsp_id, rsp_all, e0);
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge i_clk);
      $display("bp stall %0d: valid=%b id=%0d rsp=%h busy=%b", s, o_rsp_valid, o_rsp_id, rsp_all, o_busy);
      checks++;
      if ({o_rsp_valid, o_rsp_id, rsp_all} !== {1'b1, 1'b0, e0}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d %h expected v=1 id=0 %h", s, o_rsp_valid, o_rsp_id, rsp_all, e0);
      end
      checks++;
      if ({o_req0_ready, o_req1_ready, o_busy} !== 3'b001) begin
        failures++;
        $display("FAIL bp_ready_busy[%0d]: got %b expected 001", s, {o_req0_ready, o_req1_ready, o_busy});
      end
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    checks++;
    if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_single_rsp: got valid=%b expected 0", o_rsp_valid); end
    checks++;
    if ({o_req0_ready, o_req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_next_grant: got %b expected 01", {o_req0_ready, o_req1_ready});
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge i_clk);
      got = (o_rsp_valid === 1'b1);
    end
    checks++;
    if ({got, o_rsp_id, rsp_all} !== {1'b1, 1'b1, e1}) begin
      failures++;
      $display("FAIL bp_second: got ok=%b id=%0d %h expected ok=1 id=1 %h", got, o_rsp_id, rsp_all, e1);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset_mid_exec;
    bit got;
    do_reset;
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 8'h40, 8'h40, FN_ADD);
    #1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_req0_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge i_clk);
      #1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rst_accept: got no ready expected ready0"); end
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (o_busy !== 1'b1) begin failures++; $display("FAIL rst_exec_busy: got %b expected 1", o_busy); end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL rst_async_outs: got %h expected 0", all_outs); end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      checks++;
      if ({o_rsp_valid, o_busy} !== 2'b00) begin
        failures++;
        $display("FAIL rst_no_stale[%0d]: got valid/busy=%b expected 00", k, {o_rsp_valid, o_busy});
      end
    end
    drive(1'b0, 1'b1, 8'h10, 8'h01, FN_SUB);
    drive(1'b1, 1'b1, 8'h20, 8'h20, FN_ADD);
    #1;
    checks++;
    if ({o_req0_ready, o_req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rst_ptr_zero: got %b expected 10", {o_req0_ready, o_req1_ready});
    end
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge i_clk);
      got = (o_rsp_valid === 1'b1);
    end
    $display("post-reset rsp: ok=%b id=%0d rsp=%h", got, o_rsp_id, rsp_all);
    checks++;
    if ({got, o_rsp_id, rsp_all} !== {1'b1, 1'b0, model(8'h10, 8'h01, FN_SUB)}) begin
      failures++;
      $display("FAIL rst_next_op: got ok=%b id=%0d %h expected ok=1 id=0 %h", got, o_rsp_id, rsp_all, model(8'h10, 8'h01, FN_SUB));
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_random;
    bit ok, id; int lat, stall; logic rdy_after, rid;
    logic [W-1:0] a, b; logic [2:0] fn; logic [W+2:0] res, exp;
    for (int i = 0; i < 60; i++) begin
      id    = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      fn    = 3'($urandom);
      stall = int'($urandom_range(0, 3));
      exp   = model(a, b, fn);
      do_op(id, a, b, fn, stall, ok, lat, rdy_after, rid, res);
      $display("rand %0d: id=%0d a=%h b=%h fn=%b stall=%0d -> rsp=%h id=%0d lat=%0d",
               i, id, a, b, fn, stall, res, rid, lat);
      checks++;
      if ({ok, rid, res} !== {1'b1, id, exp}) begin
        failures++;
        $display("FAIL rand_result[%0d]: got ok=%b id=%0d %h expected ok=1 id=%0d %h", i, ok, rid, res, id, exp);
      end
      checks++;
      if (lat != 2) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 2", i, lat); end
      checks++;
      if (rdy_after !== 1'b0) begin failures++; $display("FAIL rand_ready_pulse[%0d]: got %b expected 0", i, rdy_after); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_exec;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
